// File: rtl/pc_sequencer_if.sv
// Request/status bundle for pc_sequencer: the master drives the control
// inputs and observes the program counter and return-stack status.
interface pc_sequencer_if #(
    parameter int LENGTH    = 11,
    parameter int OFS_W     = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);

    logic               enable;
    logic [2:0]         op;
    logic [LENGTH-1:0]  target;
    logic [OFS_W-1:0]   offset;
    logic               resume;
    logic [LENGTH-1:0]  program_count;
    logic               halted;
    logic [DEPTH_W-1:0] ras_depth;
    logic               ras_overflow;
    logic               ras_underflow;

    modport master (
        output enable, op, target, offset, resume,
        input  program_count, halted, ras_depth, ras_overflow, ras_underflow
    );

    modport slave (
        input  enable, op, target, offset, resume,
        output program_count, halted, ras_depth, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with RUN/HALTED FSM, updating on the falling edge.
// Define PC_SEQUENCER_RAS_EN to build the circular return-address stack.
module pc_sequencer #(
    parameter int                LENGTH       = 11,
    parameter int                OFS_W        = 8,
    parameter int                RAS_DEPTH    = 4,
    parameter logic [LENGTH-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.slave     bus
);
    localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    typedef enum logic {RUN, HALTED} state_t;

    state_t             state;
    logic [LENGTH-1:0]  pc;
    logic               halted_q;
    logic [LENGTH-1:0]  pc_inc;
    logic [LENGTH-1:0]  pc_br;
    logic signed [LENGTH-1:0] ofs_ext;

    assign pc_inc  = pc + LENGTH'(1);
    // Signed size cast sign-extends the displacement; the add wraps naturally.
    assign ofs_ext = LENGTH'($signed(bus.offset));
    assign pc_br   = pc + LENGTH'(ofs_ext);

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [LENGTH-1:0]  stack [RAS_DEPTH];
    logic [PTR_W-1:0]   sp;
    logic [PTR_W-1:0]   sp_top;
    logic [DEPTH_W-1:0] depth;
    logic               ovf;
    logic               unf;
    logic               full;
    logic               push;

    // sp is the next write slot; when full it also indexes the oldest entry.
    assign sp_top = sp - PTR_W'(1);
    assign full   = (depth == DEPTH_W'(RAS_DEPTH));
    assign push   = (state == RUN) && bus.enable && (bus.op == OP_CALL);

    always_ff @(negedge clk) begin
        if (push) stack[sp] <= pc_inc;
    end
`endif

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_VECTOR;
            halted_q <= 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
            sp       <= '0;
            depth    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: if (bus.enable) begin
                    case (bus.op)
                        OP_JUMP:   pc <= bus.target;
                        OP_BRANCH: pc <= pc_br;
                        OP_CALL: begin
                            pc <= bus.target;
`ifdef PC_SEQUENCER_RAS_EN
                            sp <= sp + PTR_W'(1);
                            if (full) ovf   <= 1'b1;
                            else      depth <= depth + DEPTH_W'(1);
`endif
                        end
                        OP_RET: begin
`ifdef PC_SEQUENCER_RAS_EN
                            if (depth == '0) begin
                                pc  <= pc_inc;
                                unf <= 1'b1;
                            end else begin
                                pc    <= stack[sp_top];
                                sp    <= sp_top;
                                depth <= depth - DEPTH_W'(1);
                            end
`else
                            pc <= pc_inc;
`endif
                        end
                        OP_HALT: begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end
                        default:   pc <= pc_inc;
                    endcase
                end
                HALTED: if (bus.resume) begin
                    state    <= RUN;
                    halted_q <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.program_count = pc;
    assign bus.halted        = halted_q;
`ifdef PC_SEQUENCER_RAS_EN
    assign bus.ras_depth     = depth;
    assign bus.ras_overflow  = ovf;
    assign bus.ras_underflow = unf;
`else
    assign bus.ras_depth     = '0;
    assign bus.ras_overflow  = 1'b0;
    assign bus.ras_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues hand-computed results,
// a monitor compares them on the rising edge, away from the falling update edge.
module tb_pc_sequencer;
    logic clk;
    logic reset;

    pc_sequencer_if #(.LENGTH(11), .OFS_W(8), .RAS_DEPTH(4)) bus ();

    pc_sequencer #(
        .LENGTH(11), .OFS_W(8), .RAS_DEPTH(4), .RESET_VECTOR(11'h010)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [10:0] pc;
        logic        h;
        logic [2:0]  d;
        logic        o;
        logic        u;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic xo = 1'b0;
    logic xu = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({bus.program_count, bus.halted, bus.ras_depth, bus.ras_overflow, bus.ras_underflow}
                    !== {e.pc, e.h, e.d, e.o, e.u}) begin
                    errors++;
                    $display("FAIL %s: got pc=%h halted=%b depth=%0d ovf=%b unf=%b, want pc=%h halted=%b depth=%0d ovf=%b unf=%b",
                             e.name, bus.program_count, bus.halted, bus.ras_depth, bus.ras_overflow,
                             bus.ras_underflow, e.pc, e.h, e.d, e.o, e.u);
                end
            end
        end
    end

    task automatic push_exp(input logic [10:0] pc, input logic h, input logic [2:0] d,
                            input logic o, input logic u, input string nm);
        exp_t e;
        e.pc = pc; e.h = h; e.d = d; e.o = o; e.u = u; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic en, input logic [2:0] o, input logic [10:0] t,
                        input logic [7:0] f, input logic r, input logic [10:0] epc,
                        input logic eh, input logic [2:0] ed, input string nm);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.enable = en;
        bus.op     = o;
        bus.target = t;
        bus.offset = f;
        bus.resume = r;
        push_exp(epc, eh, ed, xo, xu, nm);
    endtask

    task automatic go(input logic [2:0] o, input logic [10:0] t, input logic [7:0] f,
                      input logic [10:0] epc, input logic [2:0] ed, input string nm);
        step(1'b1, o, t, f, 1'b0, epc, 1'b0, ed, nm);
    endtask

    task automatic apply_reset(input string nm);
        @(posedge clk);
        #1;
        reset = 1'b1;
        xo = 1'b0;
        xu = 1'b0;
        push_exp(11'h010, 1'b0, 3'd0, 1'b0, 1'b0, nm);
    endtask

    initial begin : driver
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.op     = 3'd0;
        bus.target = '0;
        bus.offset = '0;
        bus.resume = 1'b0;

        apply_reset("reset_state");
        go(3'd0, 11'h000, 8'h00, 11'h011, 3'd0, "next_1");
        go(3'd0, 11'h000, 8'h00, 11'h012, 3'd0, "next_2");
        go(3'd0, 11'h000, 8'h00, 11'h013, 3'd0, "next_3");

        // Assert reset between falling edges and check before the next one.
        @(posedge clk);
        #1 bus.enable = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        push_exp(11'h010, 1'b0, 3'd0, 1'b0, 1'b0, "async_reset");

        go(3'd1, 11'h7FE, 8'h00, 11'h7FE, 3'd0, "jump_7fe");
        go(3'd0, 11'h000, 8'h00, 11'h7FF, 3'd0, "next_7ff");
        go(3'd0, 11'h000, 8'h00, 11'h000, 3'd0, "next_wrap");
        go(3'd1, 11'h003, 8'h00, 11'h003, 3'd0, "jump_003");
        go(3'd2, 11'h000, 8'hFB, 11'h7FE, 3'd0, "branch_neg_wrap");
        step(1'b0, 3'd2, 11'h000, 8'h10, 1'b0, 11'h7FE, 1'b0, 3'd0, "branch_stall");
        go(3'd2, 11'h000, 8'h7F, 11'h07D, 3'd0, "branch_pos_wrap");
        go(3'd6, 11'h000, 8'h00, 11'h07E, 3'd0, "op6_next");

        go(3'd1, 11'h020, 8'h00, 11'h020, 3'd0, "jump_020");
`ifdef PC_SEQUENCER_RAS_EN
        go(3'd3, 11'h100, 8'h00, 11'h100, 3'd1, "call_100");
        step(1'b0, 3'd4, 11'h000, 8'h00, 1'b0, 11'h100, 1'b0, 3'd1, "ret_stall");
        go(3'd4, 11'h000, 8'h00, 11'h021, 3'd0, "ret_021");
        go(3'd1, 11'h200, 8'h00, 11'h200, 3'd0, "jump_200");
        go(3'd3, 11'h300, 8'h00, 11'h300, 3'd1, "call_1");
        go(3'd3, 11'h310, 8'h00, 11'h310, 3'd2, "call_2");
        go(3'd3, 11'h320, 8'h00, 11'h320, 3'd3, "call_3");
        go(3'd3, 11'h330, 8'h00, 11'h330, 3'd4, "call_4");
        xo = 1'b1;
        go(3'd3, 11'h340, 8'h00, 11'h340, 3'd4, "call_5_overflow");
        go(3'd4, 11'h000, 8'h00, 11'h331, 3'd3, "ret_1");
        go(3'd4, 11'h000, 8'h00, 11'h321, 3'd2, "ret_2");
        go(3'd4, 11'h000, 8'h00, 11'h311, 3'd1, "ret_3");
        go(3'd4, 11'h000, 8'h00, 11'h301, 3'd0, "ret_4");
        xu = 1'b1;
        go(3'd4, 11'h000, 8'h00, 11'h302, 3'd0, "ret_5_underflow");
`else
        go(3'd3, 11'h100, 8'h00, 11'h100, 3'd0, "call_as_jump");
        step(1'b0, 3'd4, 11'h000, 8'h00, 1'b0, 11'h100, 1'b0, 3'd0, "ret_stall");
        go(3'd4, 11'h000, 8'h00, 11'h101, 3'd0, "ret_as_next");
        go(3'd1, 11'h200, 8'h00, 11'h200, 3'd0, "jump_200");
        go(3'd3, 11'h300, 8'h00, 11'h300, 3'd0, "call_1");
        go(3'd3, 11'h340, 8'h00, 11'h340, 3'd0, "call_2");
        go(3'd4, 11'h000, 8'h00, 11'h341, 3'd0, "ret_1");
        go(3'd4, 11'h000, 8'h00, 11'h342, 3'd0, "ret_2");
`endif

        go(3'd1, 11'h040, 8'h00, 11'h040, 3'd0, "jump_040");
        step(1'b1, 3'd5, 11'h000, 8'h00, 1'b0, 11'h040, 1'b1, 3'd0, "halt");
        for (int i = 0; i < 10; i++)
            step(1'b1, 3'd1, 11'h123, 8'h00, 1'b0, 11'h040, 1'b1, 3'd0, $sformatf("halted_hold_%0d", i));
        step(1'b1, 3'd4, 11'h000, 8'h00, 1'b0, 11'h040, 1'b1, 3'd0, "halted_ret_ignored");
        step(1'b1, 3'd1, 11'h555, 8'h00, 1'b1, 11'h040, 1'b0, 3'd0, "resume");
        go(3'd0, 11'h000, 8'h00, 11'h041, 3'd0, "next_after_resume");
        step(1'b1, 3'd0, 11'h000, 8'h00, 1'b1, 11'h042, 1'b0, 3'd0, "resume_in_run");
        go(3'd7, 11'h000, 8'h00, 11'h043, 3'd0, "op7_next");

        apply_reset("reset_clears_flags");
        go(3'd0, 11'h000, 8'h00, 11'h011, 3'd0, "next_after_reset");

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter LENGTH, default 11, SHALL set the program counter and target width in bits.
REQ-002 Parameter OFS_W, default 8, SHALL set the signed branch offset width (OFS_W <= LENGTH).
REQ-003 Parameter RAS_DEPTH, default 4, SHALL set the return-address stack entry count (power of two, >= 2).
REQ-004 Parameter RESET_VECTOR, default 0, SHALL set the program_count value after reset.
REQ-005 clk  in  1  single clock; all state SHALL update on its falling edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  advance permit; 0 = stall.
REQ-008 op  in  3  operation: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT; codes 6-7 SHALL act as NEXT.
REQ-009 target  in  LENGTH  absolute destination for JUMP and CALL.
REQ-010 offset  in  OFS_W  two's-complement displacement for BRANCH.
REQ-011 resume  in  1  leaves the halted state.
REQ-012 program_count  out  LENGTH  current instruction address, registered.
REQ-013 halted  out  1  high while in HALTED.
REQ-014 ras_depth  out  $clog2(RAS_DEPTH+1)  valid stack entries.
REQ-015 ras_overflow, ras_underflow  out  1 each  sticky stack error flags.

Function
REQ-016 The FSM SHALL have exactly two states, RUN and HALTED.
REQ-017 In RUN with enable=0, all registers SHALL hold, including the stack.
REQ-018 In RUN with enable=1, the edge SHALL apply op with one-edge latency.
- NEXT: pc <= pc+1
- JUMP: pc <= target
- BRANCH: pc <= pc + sign_extend(offset), relative to the current pc
- CALL: push pc+1, then pc <= target
- RET: pc <= popped entry
- HALT: pc holds, state <= HALTED
REQ-019 All pc arithmetic SHALL wrap modulo 2^LENGTH (e.g. LENGTH=11: 0x7FF+1 = 0x000; 0x002 + (-4) = 0x7FE).
REQ-020 In HALTED, op and enable SHALL be ignored and pc SHALL hold.
REQ-021 In HALTED, resume=1 SHALL return the FSM to RUN on the next edge with pc unchanged; resume SHALL be ignored in RUN.
REQ-022 CALL with ras_depth=RAS_DEPTH SHALL overwrite the oldest entry (circular stack), keep ras_depth at RAS_DEPTH, still jump, and set ras_overflow.
REQ-023 RET with ras_depth=0 SHALL set pc <= pc+1, leave ras_depth at 0, and set ras_underflow.
REQ-024 ras_overflow and ras_underflow SHALL stay set until reset.
REQ-025 halted SHALL be a registered decode of the FSM state; no output SHALL depend combinationally on inputs.

Reset
REQ-026 Asserting reset SHALL immediately, without a clock edge, force: program_count=RESET_VECTOR, state=RUN, halted=0, ras_depth=0, both flags 0.
REQ-027 Reset SHALL override every op, including a CALL or RET in flight; stack contents become don't-care once ras_depth=0.
REQ-028 The first operation after reset deassertion SHALL execute on the first falling edge at which reset is low.

Configuration
REQ-029 With macro PC_SEQUENCER_RAS_EN defined, the return-address stack and REQ-022 to REQ-024 SHALL be implemented.
REQ-030 Without PC_SEQUENCER_RAS_EN, CALL SHALL behave as JUMP and RET as NEXT, ras_depth and both flags SHALL be tied to 0, and no stack storage SHALL be inferred.

Verification
REQ-031 Reset with RESET_VECTOR=0x010, then 3 edges of NEXT with enable=1 -> pc 0x011, 0x012, 0x013; reset asserted mid-cycle -> pc 0x010 with no edge.
REQ-032 pc=0x7FE, NEXT x2 -> 0x7FF, 0x000; at pc=0x003, BRANCH offset=8'hFB -> 0x7FE; enable=0 during BRANCH -> pc holds.
REQ-033 (RAS_EN) At pc=0x020, CALL target=0x100 -> pc 0x100, depth 1; RET -> pc 0x021, depth 0.
REQ-034 (RAS_EN, RAS_DEPTH=4) 5 nested CALLs -> ras_overflow=1, depth 4; 4 RETs return the 5th..2nd return addresses; 5th RET -> pc+1 and ras_underflow=1.
REQ-035 HALT at pc=0x040 -> halted=1, pc 0x040 held for 10 edges under JUMP ops; resume=1 -> halted=0 next edge, then NEXT -> 0x041.
REQ-036 Without RAS_EN, CALL target=0x100 from 0x020 then RET -> pc 0x100 then 0x101, flags 0.
